cu_multicycle: RTL and testbench

Multicycle control unit for the RV32I processor: a successor to the single-cycle decoder, it sequences each instruction through FETCH/DECODE/EXECUTE/MEM/WRITEBACK and gates side effects to the correct cycle. Instruction and data memory are accessed over req/ack handshakes, so memories may take variable latency. It sits between the instruction register and the datapath muxes, register unit, ALU and data memory. It adds illegal-instruction and bus-timeout trapping, and an optional M-extension handshake.

---
 rtl/cu_pkg.sv | 95 +++++++++
 rtl/cu_if.sv | 47 ++++
 rtl/cu_decoder.sv | 109 ++++++++++
 rtl/cu_multicycle.sv | 188 ++++++++++++++++++
 tb/tb_cu_multicycle.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/cu_pkg.sv
// -----------------------------------------------------------------------------
// cu_pkg
// Shared types and encodings for the RV32I multicycle control unit:
// FSM state enum, opcode/funct7 constants, datapath control encodings
// (ImmSrc, BrOp, ALUOp, RUDataWrSrc), the registered decode bundle and the
// trap cause codes.
// -----------------------------------------------------------------------------
package cu_pkg;

    typedef enum logic [2:0] {
        ST_FETCH   = 3'd0,
        ST_DECODE  = 3'd1,
        ST_EXECUTE = 3'd2,
        ST_MEM     = 3'd3,
        ST_WB      = 3'd4,
        ST_TRAP    = 3'd7
    } cu_state_e;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    typedef enum logic [2:0] {
        IMM_I = 3'b000,
        IMM_S = 3'b001,
        IMM_B = 3'b010,
        IMM_U = 3'b011,
        IMM_J = 3'b100
    } imm_src_e;

    localparam logic [4:0] BR_NONE = 5'b10101;
    localparam logic [4:0] BR_JUMP = 5'b01111;

    localparam logic [4:0] ALU_ADD = 5'b00000;

    typedef enum logic [1:0] {
        WR_ALU = 2'b00,
        WR_MEM = 2'b01,
        WR_PC4 = 2'b10
    } wr_src_e;

    // Selects the EXECUTE-state successor; not visible on any port.
    typedef enum logic [2:0] {
        CLS_ALU,
        CLS_BRANCH,
        CLS_LOAD,
        CLS_STORE,
        CLS_MUL
    } instr_cls_e;

    typedef enum logic [1:0] {
        CAUSE_NONE    = 2'b00,
        CAUSE_ILLEGAL = 2'b01,
        CAUSE_TIMEOUT = 2'b10
    } trap_cause_e;

    typedef struct packed {
        instr_cls_e cls;
        imm_src_e   imm_src;
        logic       alu_a_src;   // 0: rs1, 1: PC
        logic       alu_b_src;   // 0: rs2, 1: immediate
        logic [4:0] br_op;
        logic [4:0] alu_op;
        logic [2:0] dm_ctrl;
        wr_src_e    wr_src;
    } ctrl_bundle_t;

    localparam ctrl_bundle_t BUNDLE_RESET = '{
        cls:       CLS_ALU,
        imm_src:   IMM_I,
        alu_a_src: 1'b0,
        alu_b_src: 1'b0,
        br_op:     BR_NONE,
        alu_op:    ALU_ADD,
        dm_ctrl:   3'b000,
        wr_src:    WR_ALU
    };

    // Base-ISA ALU op. The shift-right pair is inverted relative to funct7[5]:
    // srl = 1101 and sra = 0101, while add/sub follow funct7[5] directly.
    function automatic logic [4:0] base_alu_op(input logic [2:0] funct3, input logic alt);
        return {1'b0, (funct3 == 3'b101) ? ~alt : alt, funct3};
    endfunction

endpackage

// File: rtl/cu_if.sv
// -----------------------------------------------------------------------------
// cu_if
// Bundles the control unit's bus-facing signals: instruction input, the
// instruction/data memory req/ack handshakes, datapath controls, the M-unit
// handshake and trap/debug status.
//   master : control unit side (drives reqs and controls)
//   slave  : datapath / memory side (drives instruction, acks, mul done)
// -----------------------------------------------------------------------------
interface cu_if #(
    parameter int ALUOP_W = 5
);
    logic [31:0]        CUInstr;
    logic               CUIMemReq;
    logic               CUIMemAck;
    logic               CUDMemReq;
    logic               CUDMemAck;
    logic               CUIRWr;
    logic               CUPCWr;
    logic               CURUWr;
    logic [2:0]         CUImmSrc;
    logic               CUALUASrc;
    logic               CUALUBSrc;
    logic [4:0]         CUBrOp;
    logic [ALUOP_W-1:0] CUALUOp;
    logic               CUDMWr;
    logic [2:0]         CUDMCtrl;
    logic [1:0]         CURUDataWrSrc;
    logic               CUMulStart;
    logic               CUMulDone;
    logic               CUTrap;
    logic [1:0]         CUTrapCause;
    logic [2:0]         CUState;

    modport master (
        input  CUInstr, CUIMemAck, CUDMemAck, CUMulDone,
        output CUIMemReq, CUDMemReq, CUIRWr, CUPCWr, CURUWr, CUImmSrc,
               CUALUASrc, CUALUBSrc, CUBrOp, CUALUOp, CUDMWr, CUDMCtrl,
               CURUDataWrSrc, CUMulStart, CUTrap, CUTrapCause, CUState
    );

    modport slave (
        output CUInstr, CUIMemAck, CUDMemAck, CUMulDone,
        input  CUIMemReq, CUDMemReq, CUIRWr, CUPCWr, CURUWr, CUImmSrc,
               CUALUASrc, CUALUBSrc, CUBrOp, CUALUOp, CUDMWr, CUDMCtrl,
               CURUDataWrSrc, CUMulStart, CUTrap, CUTrapCause, CUState
    );
endinterface

// File: rtl/cu_decoder.sv
// -----------------------------------------------------------------------------
// cu_decoder
// Combinational RV32I instruction decoder producing the control bundle that
// the FSM registers in DECODE, plus an illegal-instruction flag.
//   instr_i   : instruction register contents
//   bundle_o  : decoded static datapath controls and instruction class
//   illegal_o : instruction is not a supported encoding
// Optional feature macro: CU_MULDIV_EN (R-type funct7 0000001 becomes legal).
// -----------------------------------------------------------------------------
module cu_decoder
    import cu_pkg::*;
(
    input  logic [31:0]  instr_i,
    output ctrl_bundle_t bundle_o,
    output logic         illegal_o
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;

    assign opcode = instr_i[6:0];
    assign funct3 = instr_i[14:12];
    assign funct7 = instr_i[31:25];

    // Register/immediate fields are consumed by the datapath, not here.
    logic unused_fields;
    assign unused_fields = ^{instr_i[24:15], instr_i[11:7]};

    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves
        // it unassigned, which would otherwise infer a latch.
        bundle_o  = BUNDLE_RESET;
        illegal_o = 1'b0;

        case (opcode)
            OPC_LUI: begin
                bundle_o.imm_src   = IMM_U;
                bundle_o.alu_b_src = 1'b1;
            end
            OPC_AUIPC: begin
                bundle_o.imm_src   = IMM_U;
                bundle_o.alu_a_src = 1'b1;
                bundle_o.alu_b_src = 1'b1;
            end
            OPC_JAL: begin
                bundle_o.imm_src   = IMM_J;
                bundle_o.alu_a_src = 1'b1;
                bundle_o.alu_b_src = 1'b1;
                bundle_o.br_op     = BR_JUMP;
                bundle_o.wr_src    = WR_PC4;
            end
            OPC_JALR: begin
                bundle_o.imm_src   = IMM_I;
                bundle_o.alu_b_src = 1'b1;
                bundle_o.br_op     = BR_JUMP;
                bundle_o.wr_src    = WR_PC4;
            end
            OPC_BRANCH: begin
                bundle_o.cls       = CLS_BRANCH;
                bundle_o.imm_src   = IMM_B;
                bundle_o.alu_a_src = 1'b1;
                bundle_o.alu_b_src = 1'b1;
                bundle_o.br_op     = {2'b00, funct3};
                illegal_o          = (funct3 == 3'b010) || (funct3 == 3'b011);
            end
            OPC_LOAD: begin
                bundle_o.cls       = CLS_LOAD;
                bundle_o.alu_b_src = 1'b1;
                bundle_o.dm_ctrl   = funct3;
                bundle_o.wr_src    = WR_MEM;
                illegal_o          = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
            end
            OPC_STORE: begin
                bundle_o.cls       = CLS_STORE;
                bundle_o.imm_src   = IMM_S;
                bundle_o.alu_b_src = 1'b1;
                bundle_o.dm_ctrl   = funct3;
                illegal_o          = (funct3 > 3'b010);
            end
            OPC_OPIMM: begin
                bundle_o.alu_b_src = 1'b1;
                // Only shifts-right use funct7[5]; elsewhere it is immediate data.
                bundle_o.alu_op    = base_alu_op(funct3, (funct3 == 3'b101) && funct7[5]);
                illegal_o          = ((funct3 == 3'b001) && (funct7 != F7_BASE)) ||
                                     ((funct3 == 3'b101) && (funct7 != F7_BASE) &&
                                      (funct7 != F7_ALT));
            end
            OPC_OP: begin
                case (funct7)
                    F7_BASE: bundle_o.alu_op = base_alu_op(funct3, 1'b0);
                    F7_ALT: begin
                        bundle_o.alu_op = base_alu_op(funct3, 1'b1);
                        illegal_o       = (funct3 != 3'b000) && (funct3 != 3'b101);
                    end
`ifdef CU_MULDIV_EN
                    F7_MULDIV: begin
                        bundle_o.cls    = CLS_MUL;
                        bundle_o.alu_op = {2'b10, funct3};
                    end
`endif
                    default: illegal_o = 1'b1;
                endcase
            end
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/cu_multicycle.sv
// -----------------------------------------------------------------------------
// cu_multicycle
// Multicycle RV32I control unit. Sequences each instruction through
// FETCH/DECODE/EXECUTE/MEM/WB, gating register, PC, IR and memory side effects
// to the proper cycle. Memories use req/ack handshakes with optional bus
// timeout; illegal instructions and timeouts enter an absorbing TRAP state.
//   CUClk  : clock, rising edge
//   CURstN : asynchronous active-low reset
//   bus    : cu_if.master - instruction, handshakes, datapath controls,
//            M-unit handshake, trap status and debug state
// Parameters: ALUOP_W (CUALUOp width), TIMEOUT (ack wait limit, 0 = off).
// Optional feature macro: CU_MULDIV_EN (M-extension handshake via
// CUMulStart/CUMulDone; without it CUMulStart is tied low).
// -----------------------------------------------------------------------------
module cu_multicycle
    import cu_pkg::*;
#(
    parameter int ALUOP_W = 5,
    parameter int TIMEOUT = 16
) (
    input  logic CUClk,
    input  logic CURstN,
    cu_if.master bus
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    cu_state_e    state_q, state_d;
    ctrl_bundle_t bundle_q, bundle_d;
    ctrl_bundle_t dec_bundle;
    logic         dec_illegal;
    trap_cause_e  cause_q, cause_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic         timed_out;

    logic ir_wr, pc_wr, ru_wr, dm_wr, imem_req, dmem_req;

`ifdef CU_MULDIV_EN
    logic mul_busy_q, mul_busy_d;
    logic mul_start;
`else
    logic unused_mul_done;
    assign unused_mul_done = bus.CUMulDone;
`endif

    cu_decoder u_decoder (
        .instr_i   (bus.CUInstr),
        .bundle_o  (dec_bundle),
        .illegal_o (dec_illegal)
    );

    // cnt_q counts completed ack-less wait cycles, so the TIMEOUT-th cycle is
    // the last one in which an ack is still accepted.
    assign timed_out = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

    always_ff @(posedge CUClk or negedge CURstN) begin
        if (!CURstN) begin
            state_q  <= ST_FETCH;
            // NOTE: the bundle drives the static controls directly, so it is
            // reset to keep every output defined before the first DECODE.
            bundle_q <= BUNDLE_RESET;
            cause_q  <= CAUSE_NONE;
            cnt_q    <= '0;
`ifdef CU_MULDIV_EN
            mul_busy_q <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values regardless of statement order.
            state_q  <= state_d;
            bundle_q <= bundle_d;
            cause_q  <= cause_d;
            cnt_q    <= cnt_d;
`ifdef CU_MULDIV_EN
            mul_busy_q <= mul_busy_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        bundle_d = bundle_q;
        cause_d  = cause_q;
        cnt_d    = '0;           // clears whenever the FSM moves on
        ir_wr    = 1'b0;
        pc_wr    = 1'b0;
        ru_wr    = 1'b0;
        dm_wr    = 1'b0;
        imem_req = 1'b0;
        dmem_req = 1'b0;
`ifdef CU_MULDIV_EN
        mul_busy_d = 1'b0;
        mul_start  = 1'b0;
`endif

        case (state_q)
            ST_FETCH: begin
                imem_req = 1'b1;
                if (bus.CUIMemAck) begin
                    ir_wr   = 1'b1;
                    state_d = ST_DECODE;
                end else if (timed_out) begin
                    state_d = ST_TRAP;
                    cause_d = CAUSE_TIMEOUT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DECODE: begin
                if (dec_illegal) begin
                    state_d = ST_TRAP;
                    cause_d = CAUSE_ILLEGAL;
                end else begin
                    bundle_d = dec_bundle;
                    state_d  = ST_EXECUTE;
                end
            end
            ST_EXECUTE: begin
                case (bundle_q.cls)
                    CLS_BRANCH: begin
                        pc_wr   = 1'b1;
                        state_d = ST_FETCH;
                    end
                    CLS_LOAD, CLS_STORE: state_d = ST_MEM;
`ifdef CU_MULDIV_EN
                    CLS_MUL: begin
                        // Start pulses only in the first EXECUTE cycle.
                        mul_start  = !mul_busy_q;
                        mul_busy_d = !bus.CUMulDone;
                        if (bus.CUMulDone) state_d = ST_WB;
                    end
`endif
                    default: state_d = ST_WB;
                endcase
            end
            ST_MEM: begin
                dmem_req = 1'b1;
                dm_wr    = (bundle_q.cls == CLS_STORE);
                if (bus.CUDMemAck) begin
                    if (bundle_q.cls == CLS_STORE) begin
                        pc_wr   = 1'b1;
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_WB;
                    end
                end else if (timed_out) begin
                    state_d = ST_TRAP;
                    cause_d = CAUSE_TIMEOUT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_WB: begin
                ru_wr   = 1'b1;
                pc_wr   = 1'b1;
                state_d = ST_FETCH;
            end
            ST_TRAP: state_d = ST_TRAP;
            default: state_d = ST_FETCH;
        endcase
    end

    // The FSM sits in FETCH while reset is held; gating the FETCH outputs with
    // CURstN keeps every side effect low during reset.
    assign bus.CUIMemReq     = imem_req & CURstN;
    assign bus.CUIRWr        = ir_wr & CURstN;
    assign bus.CUDMemReq     = dmem_req;
    assign bus.CUPCWr        = pc_wr;
    assign bus.CURUWr        = ru_wr;
    assign bus.CUDMWr        = dm_wr;
    assign bus.CUImmSrc      = bundle_q.imm_src;
    assign bus.CUALUASrc     = bundle_q.alu_a_src;
    assign bus.CUALUBSrc     = bundle_q.alu_b_src;
    assign bus.CUBrOp        = bundle_q.br_op;
    assign bus.CUALUOp       = ALUOP_W'(bundle_q.alu_op);
    assign bus.CUDMCtrl      = bundle_q.dm_ctrl;
    assign bus.CURUDataWrSrc = bundle_q.wr_src;
    assign bus.CUTrap        = (state_q == ST_TRAP);
    assign bus.CUTrapCause   = cause_q;
    assign bus.CUState       = state_q;
`ifdef CU_MULDIV_EN
    assign bus.CUMulStart    = mul_start;
`else
    assign bus.CUMulStart    = 1'b0;
`endif

endmodule

// File: tb/tb_cu_multicycle.sv
// -----------------------------------------------------------------------------
// tb_cu_multicycle
// Directed bench for cu_multicycle with hand-computed expectations. Each
// instruction is run through run_instr, which answers the handshakes with a
// chosen latency and records the state trace (one nibble per cycle) and the
// side-effect pulses; the test body then compares the record with constants.
// -----------------------------------------------------------------------------
module tb_cu_multicycle;
    import cu_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cu_if #(.ALUOP_W(5)) bus ();

    cu_multicycle #(.ALUOP_W(5), .TIMEOUT(16)) dut (
        .CUClk  (clk),
        .CURstN (rst_n),
        .bus    (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [63:0] tr;
    int   n_fetch, n_pcwr, pcwr_st, n_ruwr, ruwr_st, n_dmwr, n_irwr, n_mulstart;
    logic first_req;
    logic [4:0] alu_s, br_s;
    logic [2:0] imm_s, dm_s;
    logic [1:0] wr_s;
    logic       asrc_s, bsrc_s;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Runs one instruction starting at a negedge in FETCH. Acks/done are
    // raised once the FSM has spent idelay/ddelay/mdelay cycles in the state.
    // Returns at the negedge of the next FETCH, or just after sampling TRAP.
    task automatic run_instr(input logic [31:0] instr, input int idelay,
                             input int ddelay, input int mdelay);
        int k_f = 0, k_m = 0, k_e = 0;
        bit left_fetch = 0, done = 0;
        logic [2:0] st;
        tr = '0; n_pcwr = 0; pcwr_st = -1; n_ruwr = 0; ruwr_st = -1;
        n_dmwr = 0; n_irwr = 0; n_mulstart = 0; first_req = 1'b0;
        alu_s = '1; br_s = '1; imm_s = '1; dm_s = '1; wr_s = '1; asrc_s = 1'bx; bsrc_s = 1'bx;
        bus.CUInstr = instr;
        for (int cyc = 0; cyc < 80 && !done; cyc++) begin
            st = bus.CUState;
            if (left_fetch && st == ST_FETCH) begin
                done = 1;
            end else begin
                bus.CUIMemAck = (st == ST_FETCH)   && (k_f >= idelay);
                bus.CUDMemAck = (st == ST_MEM)     && (k_m >= ddelay);
                bus.CUMulDone = (st == ST_EXECUTE) && (k_e >= mdelay);
                #1;
                tr = (tr << 4) | 64'(st);
                if (cyc == 0) first_req = bus.CUIMemReq;
                if (bus.CUPCWr) begin n_pcwr++; pcwr_st = int'(st); end
                if (bus.CURUWr) begin n_ruwr++; ruwr_st = int'(st); end
                if (bus.CUDMWr) n_dmwr++;
                if (bus.CUIRWr) n_irwr++;
                if (bus.CUMulStart) n_mulstart++;
                if (st == ST_EXECUTE && k_e == 0) begin
                    alu_s = bus.CUALUOp; br_s = bus.CUBrOp; imm_s = bus.CUImmSrc;
                    dm_s = bus.CUDMCtrl; wr_s = bus.CURUDataWrSrc;
                    asrc_s = bus.CUALUASrc; bsrc_s = bus.CUALUBSrc;
                end
                if (st == ST_FETCH)   k_f++;
                if (st == ST_MEM)     k_m++;
                if (st == ST_EXECUTE) k_e++;
                if (st != ST_FETCH) left_fetch = 1;
                if (st == ST_TRAP) done = 1;
                else @(negedge clk);
            end
        end
        n_fetch = k_f;
        bus.CUIMemAck = 1'b0; bus.CUDMemAck = 1'b0; bus.CUMulDone = 1'b0;
        if (!done) check("run_budget", 64'd0, 64'd1);
    endtask

    // Pulses reset for two cycles, checks the reset state, releases at a negedge.
    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.CUIMemAck = 1'b0; bus.CUDMemAck = 1'b0; bus.CUMulDone = 1'b0;
        #1;
        check("rst_state", bus.CUState, 0);
        check("rst_trap",  {bus.CUTrap, bus.CUTrapCause}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.CUInstr = 32'h0000_0013;
        bus.CUIMemAck = 1'b1;          // must be ignored while reset is held
        bus.CUDMemAck = 1'b0;
        bus.CUMulDone = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_state0", bus.CUState, 0);
        check("rst_imemreq", bus.CUIMemReq, 0);
        check("rst_irwr", bus.CUIRWr, 0);
        check("rst_brop", bus.CUBrOp, 5'b10101);
        check("rst_misc", {bus.CUALUOp, bus.CUPCWr, bus.CURUWr, bus.CUDMemReq, bus.CUTrap}, 0);
        bus.CUIMemAck = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // add x3,x1,x2 zero-wait: F D E WB
        run_instr(32'h0020_81B3, 0, 0, 0);
        check("add_req_first", first_req, 1);
        check("add_trace", tr, 64'h0124);
        check("add_ruwr", {n_ruwr, ruwr_st}, {32'd1, 32'd4});
        check("add_pcwr", {n_pcwr, pcwr_st}, {32'd1, 32'd4});
        check("add_irwr", n_irwr, 1);
        check("add_ctrl", {alu_s, wr_s}, {5'b00000, 2'b00});

        // lw x3,0(x1), data ack on the 4th MEM cycle
        run_instr(32'h0000_A183, 0, 3, 0);
        check("lw_trace", tr, 64'h0123_3334);
        check("lw_ctrl", {dm_s, wr_s, imm_s, bsrc_s}, {3'b010, 2'b01, 3'b000, 1'b1});
        check("lw_pulses", {n_pcwr, n_ruwr, n_dmwr}, {32'd1, 32'd1, 32'd0});

        // sw x2,0(x1)
        run_instr(32'h0020_A023, 0, 0, 0);
        check("sw_trace", tr, 64'h0123);
        check("sw_pulses", {n_dmwr, n_ruwr, n_pcwr, pcwr_st}, {32'd1, 32'd0, 32'd1, 32'd3});
        check("sw_ctrl", {imm_s, dm_s}, {3'b001, 3'b010});

        // beq x1,x2,+8
        run_instr(32'h0020_8463, 0, 0, 0);
        check("beq_trace", tr, 64'h012);
        check("beq_ctrl", {br_s, imm_s}, {5'b00000, 3'b010});
        check("beq_pcwr", {n_pcwr, pcwr_st, n_ruwr}, {32'd1, 32'd2, 32'd0});

        // addi x1,x0,5 with instruction ack on the 3rd FETCH cycle
        run_instr(32'h0050_0093, 2, 0, 0);
        check("addi_trace", tr, 64'h0001_24);
        check("addi_ctrl", {alu_s, imm_s, bsrc_s, br_s}, {5'b00000, 3'b000, 1'b1, 5'b10101});

        run_instr(32'h4030_D093, 0, 0, 0);   // srai x1,x1,3
        check("srai_alu", alu_s, 5'b00101);
        run_instr(32'h0020_D1B3, 0, 0, 0);   // srl x3,x1,x2
        check("srl_alu", alu_s, 5'b01101);
        run_instr(32'h4020_81B3, 0, 0, 0);   // sub x3,x1,x2
        check("sub_alu", alu_s, 5'b01000);

        // jal x1,0 writes PC+4 through WB
        run_instr(32'h0000_00EF, 0, 0, 0);
        check("jal_trace", tr, 64'h0124);
        check("jal_ctrl", {br_s, wr_s, imm_s}, {5'b01111, 2'b10, 3'b100});
        check("jal_pulses", {n_pcwr, n_ruwr}, {32'd1, 32'd1});

        run_instr(32'h0000_10B7, 0, 0, 0);   // lui x1,1
        check("lui_ctrl", {imm_s, asrc_s, bsrc_s}, {3'b011, 1'b0, 1'b1});
        run_instr(32'h0000_1097, 0, 0, 0);   // auipc x1,1
        check("auipc_ctrl", {imm_s, asrc_s, bsrc_s}, {3'b011, 1'b1, 1'b1});

        // Instruction ack on the 16th FETCH cycle still wins over the timeout.
        run_instr(32'h0020_81B3, 15, 0, 0);
        check("to_edge_fetch", n_fetch, 16);
        check("to_edge_trace", tr, 64'h124);

        // mul x3,x1,x2
        run_instr(32'h0220_81B3, 0, 0, 4);
`ifdef CU_MULDIV_EN
        check("mul_trace", tr, 64'h0122_2224);
        check("mul_start", n_mulstart, 1);
        check("mul_ctrl", {alu_s, n_ruwr}, {5'b10000, 32'd1});
`else
        check("mul_trace", tr, 64'h017);
        check("mul_cause", bus.CUTrapCause, 2'b01);
        check("mul_start", n_mulstart, 0);
`endif
        apply_reset();

        // Unknown opcode 0x7F traps and stays trapped.
        run_instr(32'h0000_007F, 0, 0, 0);
        check("ill_trace", tr, 64'h017);
        check("ill_cause", {bus.CUTrap, bus.CUTrapCause}, 3'b101);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.CUIMemAck = 1'b1;
            #1;
            check("ill_hold", {bus.CUState, bus.CUTrap, bus.CUIMemReq, bus.CUPCWr, bus.CUIRWr},
                  {3'd7, 1'b1, 3'b000});
        end
        apply_reset();

        // Load with funct3 011 is illegal.
        run_instr(32'h0000_B183, 0, 0, 0);
        check("ld_ill", {tr, 30'd0, bus.CUTrapCause}, {64'h017, 30'd0, 2'b01});
        apply_reset();

        // Withheld instruction ack: 16 FETCH cycles then TRAP cause 10.
        run_instr(32'h0020_81B3, 100, 0, 0);
        check("to_fetch", n_fetch, 16);
        check("to_trace", tr, 64'h7);
        check("to_cause", {bus.CUTrap, bus.CUTrapCause}, 3'b110);
        apply_reset();

        // Reset in the middle of a load's MEM wait.
        bus.CUInstr = 32'h0000_A183;
        bus.CUIMemAck = 1'b1;
        @(negedge clk);
        bus.CUIMemAck = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("mid_mem", {bus.CUState, bus.CUDMemReq, bus.CUDMCtrl}, {3'd3, 1'b1, 3'b010});
        rst_n = 1'b0;
        #1;
        check("mid_rst", {bus.CUState, bus.CUDMemReq, bus.CUPCWr, bus.CURUWr, bus.CUIMemReq},
              {3'd0, 4'b0000});
        check("mid_rst_ctrl", {bus.CUDMCtrl, bus.CUBrOp, bus.CURUDataWrSrc},
              {3'b000, 5'b10101, 2'b00});
        @(negedge clk);
        rst_n = 1'b1;
        run_instr(32'h0020_81B3, 0, 0, 0);
        check("mid_recover", {tr, n_pcwr}, {64'h0124, 32'd1});

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
